// File: rtl/vga_text_ram_arbiter.sv
// vga_text_ram_arbiter: one-slot-per-cycle arbiter sharing the text character RAM between display, host and clear
module vga_text_ram_arbiter #(
    parameter int COLS = 40,
    parameter int ROWS = 15,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_wr_valid,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_ready,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_ack,
    output logic [DATA_W-1:0] host_rd_data,
    input  logic              clear_req,
    output logic              busy,
    output logic [2:0]        fifo_count,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam int CELLS = COLS * ROWS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CELLS_A = ADDR_W'(CELLS);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(CELLS - 1);
    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, CLEAR, RD_WAIT} state_t;
    typedef enum logic [1:0] {T_NONE, T_DISP, T_HOST} tag_t;

    state_t state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic busy_q;
    logic [ADDR_W-1:0] fa_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fd_q [FIFO_DEPTH];
    logic [PW-1:0] wp_q, rp_q;
    logic [2:0] count_q;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    tag_t tag1_q, tag2_q, tag_d;
    logic zero1_q, zero2_q, zero_d;
    logic fifo_empty, fifo_full, push, drain, clr_go, clr_slot, rd_grant;
    logic disp_in, rd_in, head_in;
    logic [ADDR_W-1:0] head_addr;

    assign fifo_empty = count_q == 3'd0;
    assign fifo_full = count_q == DEPTH_C;
    assign host_wr_ready = !fifo_full && state_q != CLEAR && !RESET;
    assign push = host_wr_valid && host_wr_ready;
    assign head_addr = fa_q[rp_q];
    assign disp_in = disp_addr < CELLS_A;
    assign rd_in = host_rd_addr < CELLS_A;
    assign head_in = head_addr < CELLS_A;
    assign clr_go = state_q == IDLE && clear_req;
    assign clr_slot = state_q == CLEAR && !disp_req;
    // a read may only pass the FIFO once every earlier write has reached the RAM
    assign rd_grant = state_q == IDLE && !clear_req && !disp_req && host_rd_req && fifo_empty
                      && tag1_q != T_HOST && tag2_q != T_HOST;
    assign drain = ((state_q == IDLE && !clear_req) || state_q == RD_WAIT) && !disp_req && !rd_grant && !fifo_empty;
    assign tag_d = disp_req ? T_DISP : rd_grant ? T_HOST : T_NONE;
    assign zero_d = disp_req ? !disp_in : rd_grant && !rd_in;

    assign disp_valid = tag2_q == T_DISP;
    assign disp_data = (disp_valid && !zero2_q) ? ram_rdata : '0;
    assign host_rd_ack = tag2_q == T_HOST;
    assign host_rd_data = (host_rd_ack && !zero2_q) ? ram_rdata : '0;
    assign busy = busy_q;
    assign fifo_count = count_q;
    assign ram_addr = ram_addr_q;
    assign ram_we = ram_we_q;
    assign ram_wdata = ram_wdata_q;

    // slot owner drives the RAM port; out-of-range accesses leave the address untouched
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_we_d = 1'b0;
        ram_wdata_d = ram_wdata_q;
        if (disp_req) begin
            ram_addr_d = disp_in ? disp_addr : ram_addr_q;
        end else if (clr_slot) begin
            ram_addr_d = cnt_q;
            ram_we_d = 1'b1;
            ram_wdata_d = FILL_CHAR;
        end else if (rd_grant) begin
            ram_addr_d = rd_in ? host_rd_addr : ram_addr_q;
        end else if (drain && head_in) begin
            ram_addr_d = head_addr;
            ram_we_d = 1'b1;
            ram_wdata_d = fd_q[rp_q];
        end
    end

    // control FSM with clear counter and registered busy flag
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q <= IDLE;
            cnt_q <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= state_q == CLEAR || clr_go;
            case (state_q)
                IDLE: begin
                    if (clear_req) begin
                        state_q <= CLEAR;
                        cnt_q <= '0;
                    end else if (rd_grant) begin
                        state_q <= RD_WAIT;
                    end
                end
                CLEAR: begin
                    if (clr_slot) begin
                        cnt_q <= cnt_q == LAST_A ? '0 : cnt_q + 1'b1;
                        state_q <= cnt_q == LAST_A ? IDLE : CLEAR;
                    end
                end
                RD_WAIT: state_q <= host_rd_ack ? IDLE : RD_WAIT;
                default: state_q <= IDLE;
            endcase
        end
    end

    // host write FIFO, flushed by reset and by entering clear
    always_ff @(posedge CLOCK_50) begin
        if (RESET || clr_go) begin
            wp_q <= '0;
            rp_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fa_q[wp_q] <= host_wr_addr;
                fd_q[wp_q] <= host_wr_data;
                wp_q <= wp_q + 1'b1;
            end
            if (drain) rp_q <= rp_q + 1'b1;
            count_q <= count_q + {2'b0, push} - {2'b0, drain};
        end
    end

    // registered RAM port and two-stage tag pipeline steering read data to its consumer
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            ram_addr_q <= '0;
            ram_we_q <= 1'b0;
            ram_wdata_q <= '0;
            tag1_q <= T_NONE;
            tag2_q <= T_NONE;
            zero1_q <= 1'b0;
            zero2_q <= 1'b0;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_we_q <= ram_we_d;
            ram_wdata_q <= ram_wdata_d;
            tag1_q <= tag_d;
            tag2_q <= tag1_q;
            zero1_q <= zero_d;
            zero2_q <= zero1_q;
        end
    end
endmodule

// File: doc/vga_text_ram_arbiter.md
Name: vga_text_ram_arbiter

Overview:
- Shares the single-port character RAM of the 40x15 text-mode VGA display between three users: the display fetch path, a host read/write port and a built-in screen-clear sequencer.
- The display fetch is driven by the timing generator's charX/charY and has absolute priority, so it is never stalled.
- Host writes are buffered in a small FIFO; host reads use a request/acknowledge handshake.
- Sits between the VGA timing/pixel pipeline and the character RAM.

Parameters:
- COLS, 40, text columns
- ROWS, 15, text rows
- CELLS, COLS*ROWS (600), derived; number of valid cell addresses
- ADDR_W, 10, cell address width
- DATA_W, 8, character code width
- FIFO_DEPTH, 4, host write FIFO entries (power of two)
- FILL_CHAR, 8'h20, value written by clear

Ports:
- CLOCK_50  in  1  system clock; every register uses its rising edge
- RESET  in  1  synchronous, active-high reset
- disp_req  in  1  one-cycle display fetch request
- disp_addr  in  ADDR_W  display cell address (charY*COLS+charX)
- disp_valid  out  1  display data valid pulse
- disp_data  out  DATA_W  fetched character
- host_wr_valid  in  1  host write offer
- host_wr_addr  in  ADDR_W  host write address
- host_wr_data  in  DATA_W  host write data
- host_wr_ready  out  1  FIFO can accept
- host_rd_req  in  1  level read request, held until ack
- host_rd_addr  in  ADDR_W  read address, stable while req high
- host_rd_ack  out  1  one-cycle read completion
- host_rd_data  out  DATA_W  read data, valid with ack
- clear_req  in  1  start screen clear
- busy  out  1  clear in progress
- fifo_count  out  3  host FIFO occupancy 0..FIFO_DEPTH
- ram_addr  out  ADDR_W  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_W  RAM write data (registered)
- ram_rdata  in  DATA_W  RAM read data, 1-cycle latency after ram_addr

Behaviour:
- Reset
  - All outputs are 0; host_wr_ready is 0 while RESET is high.
  - FIFO is emptied, state goes to IDLE, clear counter is 0, tag pipeline is cleared.
  - A reset mid-clear or mid-read aborts the operation with no ack.
- Slot model
  - One RAM slot per cycle, granted at cycle S; ram_* are driven at S+1 and read data is captured at S+2.
  - Slot priority: disp_req > clear write > host read > FIFO drain.
- Display fetch
  - disp_req at S gives disp_valid=1 and disp_data=ram_rdata at S+2 (fixed 2-cycle latency), including back-to-back requests.
  - If disp_addr>=CELLS there is no RAM access: ram_we=0 and ram_addr holds its previous value; disp_valid still fires at S+2 with data 0.
- FSM states
  - IDLE:
    - Host read slot is taken only when fifo_count==0 (read-after-write ordering) and no read is outstanding.
    - Otherwise the FIFO head drains one entry per free slot.
    - clear_req moves to CLEAR.
  - CLEAR:
    - Entered on clear_req in IDLE; the FIFO is flushed (entries discarded) on entry, and busy=1 from the next cycle.
    - host_wr_ready=0; host reads wait.
    - Each slot not taken by the display writes FILL_CHAR to the counter address, then increments the counter.
    - After address CELLS-1 is written, return to IDLE; busy drops the following cycle.
    - clear_req while in CLEAR is ignored.
  - RD_WAIT:
    - Entered when a read slot is granted.
    - host_rd_ack=1 with host_rd_data at S+2, then return to IDLE.
    - FIFO drain continues in free slots.
    - host_rd_req must be low in the ack cycle to avoid a repeat read.
- Host write FIFO
  - A write is accepted when host_wr_valid && host_wr_ready, with host_wr_ready = !full && state!=CLEAR && !RESET.
  - Accepting and draining in the same cycle leaves fifo_count unchanged.
  - A drained entry with addr>=CELLS is discarded (ram_we stays 0) but still consumes the slot.
  - A host read of addr>=CELLS returns 0 with ack at S+2 and makes no RAM access.
- Tag pipeline
  - A 2-stage tag {none, disp, host_rd} routes ram_rdata to the correct consumer.
  - Write slots carry the "none" tag.

Test Plan:
- Reset, then 3 host writes (addr 5/6/7, data 8'h41/42/43) with no disp_req → ram_we pulses at three consecutive cycles and fifo_count returns to 0.
- disp_req held every cycle for 5 cycles while the FIFO holds 2 entries → no ram_we during the 5 cycles, disp_valid for 5 consecutive cycles 2 cycles later, FIFO drains afterwards.
- Write addr 12 = 8'h58, then immediately host_rd_req addr 12 → ack only after the FIFO empties, host_rd_data=8'h58.
- clear_req with no display traffic → busy high; exactly 600 writes of 8'h20 to addresses 0..599; busy low 601 cycles after busy rose; a read of addr 599 returns 8'h20.
- clear_req with disp_req every 32 cycles → clear completes in 600 + (number of stolen slots) cycles, and every disp_valid arrives at exactly request+2.
- RESET asserted mid-clear at counter 300 with a full FIFO → next cycle busy=0, fifo_count=0, host_wr_ready=0 during reset and 1 after; writes of addr 700 are accepted but ram_we is never asserted.
